uart_tx_param: RTL and testbench

//  Parametrised UART transmitter; successor to the fixed 8-bit Tx. Serialises one

---
 rtl/uart_tx_param.sv | 158 +++++++++++++++
 tb/tb_uart_tx_param.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_param.sv
// ---------------------------------------------------------------------------
// uart_tx_param
// Parametrised UART transmitter. Each accepted DATA_W-bit word is sent as one
// frame: a start bit (0), the data bits LSB first, an optional even/odd parity
// bit and STOP_BITS stop bits (1). Every serial bit is held for CLKS_PER_BIT
// clocks. The upstream side is a plain valid/ready handshake.
//
// Ports
//   clk       in   1       clock, all state changes on the rising edge
//   rst       in   1       asynchronous, active-high reset
//   tx_data   in   DATA_W  word to send, sampled only when accepted
//   tx_valid  in   1       tx_data holds a word to send
//   tx_ready  out  1       a word can be accepted (high only in IDLE)
//   u_tx      out  1       serial line, idles high
//   tx_busy   out  1       a frame is in progress
//   tx_done   out  1       one-cycle pulse in the first IDLE cycle after a frame
// ---------------------------------------------------------------------------
module uart_tx_param #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              u_tx,
  output logic              tx_busy,
  output logic              tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = $clog2(DATA_W);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  baud_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic [DATA_W-1:0] data_reg;
  logic              bit_end;
  logic              parity_bit;
  logic [IDX_W-1:0]  next_idx;

  assign bit_end    = (baud_cnt == CNT_W'(CLKS_PER_BIT - 1));
  assign parity_bit = (PARITY_ODD != 0) ? ~(^data_reg) : (^data_reg);
  assign next_idx   = bit_idx + IDX_W'(1);

  // The line value for the next bit is loaded at the same edge that moves the
  // FSM on, so u_tx is a plain register and only changes at bit boundaries.
  // bit_idx counts data bits in DATA and is reused to count stop bits in STOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      data_reg <= '0;
      u_tx     <= 1'b1;
      tx_busy  <= 1'b0;
      tx_done  <= 1'b0;
      tx_ready <= 1'b1;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          u_tx     <= 1'b1;
          if (tx_valid) begin
            data_reg <= tx_data;
            state    <= START;
            u_tx     <= 1'b0;
            tx_ready <= 1'b0;
            tx_busy  <= 1'b1;
          end
        end

        START: begin
          if (bit_end) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            u_tx     <= data_reg[0];
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_W'(DATA_W - 1)) begin
              bit_idx <= '0;
              if (PARITY_EN != 0) begin
                state <= PARITY;
                u_tx  <= parity_bit;
              end else begin
                state <= STOP;
                u_tx  <= 1'b1;
              end
            end else begin
              bit_idx <= next_idx;
              u_tx    <= data_reg[next_idx];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        PARITY: begin
          if (bit_end) begin
            baud_cnt <= '0;
            state    <= STOP;
            u_tx     <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            baud_cnt <= '0;
            if (bit_idx == IDX_W'(STOP_BITS - 1)) begin
              bit_idx  <= '0;
              state    <= IDLE;
              tx_done  <= 1'b1;
              tx_ready <= 1'b1;
              tx_busy  <= 1'b0;
            end else begin
              bit_idx <= next_idx;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          bit_idx  <= '0;
          u_tx     <= 1'b1;
          tx_busy  <= 1'b0;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_param
// Three transmitters with different parameter sets run side by side:
//   0: defaults (8 data bits, even parity, 1 stop, 16 clocks/bit)
//   1: odd parity, 2 clocks/bit
//   2: 7 data bits, no parity, 2 stop bits, 16 clocks/bit
// Drivers push the expected word and its accept cycle into a per-DUT queue;
// a monitor per DUT watches the line like a receiver, pops the queue when a
// start bit appears and compares every bit against a frame model.
// ---------------------------------------------------------------------------
module tb_uart_tx_param;

  localparam int CFG_W    [3] = '{8, 8, 7};
  localparam int CFG_CPB  [3] = '{16, 2, 16};
  localparam int CFG_PEN  [3] = '{1, 1, 0};
  localparam int CFG_PODD [3] = '{0, 1, 0};
  localparam int CFG_STOP [3] = '{1, 1, 2};

  typedef struct {
    int word;
    int acc;
  } exp_t;

  logic       clk;
  logic [2:0] rst;
  logic [2:0] valid;
  logic [2:0] ready;
  logic [2:0] line;
  logic [2:0] busy;
  logic [2:0] done;
  logic [7:0] d0;
  logic [7:0] d1;
  logic [6:0] d2;
  bit   [2:0] abort;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  uart_tx_param u_dut0 (
    .clk(clk), .rst(rst[0]), .tx_data(d0), .tx_valid(valid[0]),
    .tx_ready(ready[0]), .u_tx(line[0]), .tx_busy(busy[0]), .tx_done(done[0])
  );

  uart_tx_param #(.PARITY_ODD(1), .CLKS_PER_BIT(2)) u_dut1 (
    .clk(clk), .rst(rst[1]), .tx_data(d1), .tx_valid(valid[1]),
    .tx_ready(ready[1]), .u_tx(line[1]), .tx_busy(busy[1]), .tx_done(done[1])
  );

  uart_tx_param #(.DATA_W(7), .PARITY_EN(0), .STOP_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst[2]), .tx_data(d2), .tx_valid(valid[2]),
    .tx_ready(ready[2]), .u_tx(line[2]), .tx_busy(busy[2]), .tx_done(done[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Expected line level for bit j of a frame, from the framing rules alone.
  function automatic int model_bit(input int word, input int k, input int j);
    int w = CFG_W[k];
    if (j == 0) return 0;
    if (j <= w) return (word >> (j - 1)) & 1;
    if (CFG_PEN[k] != 0 && j == w + 1) return ($countones(word) + CFG_PODD[k]) % 2;
    return 1;
  endfunction

  task automatic checkOutput(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic setData(input int k, input int v);
    case (k)
      0: d0 = v[7:0];
      1: d1 = v[7:0];
      default: d2 = v[6:0];
    endcase
  endtask

  task automatic qPush(input int k, input exp_t e);
    case (k)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  function automatic int qSize(input int k);
    case (k)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  function automatic exp_t qPop(input int k);
    case (k)
      0: return q0.pop_front();
      1: return q1.pop_front();
      default: return q2.pop_front();
    endcase
  endfunction

  // Starts and ends on a falling edge. hold keeps tx_valid high after the
  // accept; churn scrambles tx_data every cycle while the frame is sent.
  task automatic applyStimulus(input int k, input int word, input bit hold, input bit churn);
    int   budget = 0;
    exp_t e;
    int   m = word & ((1 << CFG_W[k]) - 1);
    valid[k] = 1'b1;
    setData(k, m);
    while (!ready[k] && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    if (!ready[k]) begin
      checkOutput($sformatf("dut%0d ready_timeout", k), 0, 1);
      valid[k] = 1'b0;
      return;
    end
    e.word = m;
    e.acc  = cyc + 1;
    qPush(k, e);
    @(negedge clk);
    if (!hold || churn) valid[k] = 1'b0;
    if (churn) begin
      budget = 0;
      while (busy[k] && budget < 5000) begin
        setData(k, $urandom);
        @(negedge clk);
        budget++;
      end
    end
  endtask

  task automatic monitor(input int k);
    int   cpb = CFG_CPB[k];
    int   total = CFG_CPB[k] * (1 + CFG_W[k] + CFG_PEN[k] + CFG_STOP[k]);
    int   errs;
    int   ctrl_bad;
    int   expb;
    bit   aborted;
    bit   have;
    exp_t e;
    forever begin
      @(negedge clk);
      if (done[k]) checkOutput($sformatf("dut%0d spurious_done", k), 1, 0);
      if (line[k] == 1'b0 && !rst[k]) begin
        have = (qSize(k) != 0);
        if (have) begin
          e = qPop(k);
          checkOutput($sformatf("dut%0d start_cycle", k), cyc, e.acc);
        end else begin
          checkOutput($sformatf("dut%0d unexpected_frame", k), 1, 0);
        end
        errs = 0;
        ctrl_bad = 0;
        aborted = 1'b0;
        for (int c = 0; c < total; c++) begin
          if (c > 0) @(negedge clk);
          if (abort[k]) begin
            abort[k] = 1'b0;
            aborted = 1'b1;
            break;
          end
          if (ready[k] || !busy[k] || done[k]) ctrl_bad++;
          if (have) begin
            expb = model_bit(e.word, k, c / cpb);
            if (int'(line[k]) != expb) errs++;
            if (c % cpb == cpb / 2)
              checkOutput($sformatf("dut%0d word%0h bit%0d", k, e.word, c / cpb), int'(line[k]), expb);
          end
        end
        if (!aborted) begin
          if (have) checkOutput($sformatf("dut%0d line_cycles", k), errs, 0);
          checkOutput($sformatf("dut%0d ctrl_in_frame", k), ctrl_bad, 0);
          @(negedge clk);
          checkOutput($sformatf("dut%0d done_pulse", k), int'(done[k]), 1);
          checkOutput($sformatf("dut%0d ready_after", k), int'(ready[k]), 1);
          checkOutput($sformatf("dut%0d busy_after", k), int'(busy[k]), 0);
          checkOutput($sformatf("dut%0d idle_line", k), int'(line[k]), 1);
        end
      end
    end
  endtask

  // Reset dut0 in the middle of data bit 3 of a frame.
  task automatic resetMidFrame();
    applyStimulus(0, 'h96, 1'b0, 1'b0);
    repeat (69) @(negedge clk);
    #2;
    abort[0] = 1'b1;
    rst[0]   = 1'b1;
    #1;
    checkOutput("rst_async line", int'(line[0]), 1);
    checkOutput("rst_async ready", int'(ready[0]), 1);
    checkOutput("rst_async busy", int'(busy[0]), 0);
    checkOutput("rst_async done", int'(done[0]), 0);
    repeat (3) @(negedge clk);
    rst[0] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int budget;
    rst   = 3'b111;
    valid = 3'b000;
    abort = 3'b000;
    d0 = '0;
    d1 = '0;
    d2 = '0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("dut%0d reset line", k), int'(line[k]), 1);
      checkOutput($sformatf("dut%0d reset ready", k), int'(ready[k]), 1);
      checkOutput($sformatf("dut%0d reset busy", k), int'(busy[k]), 0);
      checkOutput($sformatf("dut%0d reset done", k), int'(done[k]), 0);
    end
    rst = 3'b000;
    @(negedge clk);

    fork
      monitor(0);
      monitor(1);
      monitor(2);
    join_none

    fork
      begin
        applyStimulus(0, 'hA5, 1'b0, 1'b0);
        applyStimulus(0, 'h3C, 1'b1, 1'b0);
        applyStimulus(0, 'hC3, 1'b0, 1'b0);
        resetMidFrame();
        applyStimulus(0, 'h5A, 1'b0, 1'b0);
        applyStimulus(0, 'h81, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++)
          applyStimulus(0, $urandom_range(0, 255), (i < 3) && ($urandom_range(0, 1) == 1), 1'b0);
      end
      begin
        applyStimulus(1, 'h00, 1'b0, 1'b0);
        applyStimulus(1, 'hFF, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++)
          applyStimulus(1, $urandom_range(0, 255), (i < 11) && ($urandom_range(0, 1) == 1),
                        $urandom_range(0, 1) == 1);
      end
      begin
        applyStimulus(2, 'h55, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++)
          applyStimulus(2, $urandom_range(0, 127), (i < 3) && ($urandom_range(0, 1) == 1), 1'b0);
      end
    join

    budget = 0;
    while ((qSize(0) + qSize(1) + qSize(2) != 0 || busy != 3'b000) && budget < 5000) begin
      @(negedge clk);
      budget++;
    end
    repeat (4) @(negedge clk);
    for (int k = 0; k < 3; k++)
      checkOutput($sformatf("dut%0d frames_outstanding", k), qSize(k), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
